// File: rtl/seq_shift_unit.sv
// Iterative one-bit-per-clock shifter with start/busy/done handshake (logical, arithmetic, optional rotate).
// Optional feature macro: SHIFT_ROTATE_EN enables rotate when rot=1; otherwise rot is ignored.
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             arith,
  input  logic             rot,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} st_t;

  st_t              state, nstate;
  logic [WIDTH-1:0] w, nxt_w;
  logic [SHW-1:0]   cnt;
  logic             dir_q, arith_q;

`ifdef SHIFT_ROTATE_EN
  logic rot_q;
`else
  logic rot_q;
  logic unused_rot;
  assign rot_q      = 1'b0;
  assign unused_rot = rot;
`endif

  // one-bit step of the working register; rotate takes precedence over fill mode
  always_comb begin
    nxt_w = w;
    if (rot_q)
      nxt_w = dir_q ? {w[WIDTH-2:0], w[WIDTH-1]} : {w[0], w[WIDTH-1:1]};
    else if (dir_q)
      nxt_w = {w[WIDTH-2:0], 1'b0};
    else
      nxt_w = {(arith_q & w[WIDTH-1]), w[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = (shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == SHW'(1)) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w       <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          w       <= operand;
          cnt     <= shamt;
          dir_q   <= dir;
          arith_q <= arith;
          if (shamt == '0) result <= operand;
        end
        SHIFT: begin
          w   <= nxt_w;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) result <= nxt_w;
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_ROTATE_EN
  always_ff @(posedge clk) begin
    if (rst)                        rot_q <= 1'b0;
    else if (state == IDLE && start) rot_q <= rot;
  end
`endif

endmodule
